rx_frame_decoder: RTL and testbench
===================================

RX_FRAME_DECODER -- requirements
Module: rx_frame_decoder

Interface
REQ-001 SHALL have parameter FRAME_CNT_W, default 16: width of frame_count.
REQ-002 SHALL have port clk  input  1  byte clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port byte_valid  input  1  decoded byte present this cycle.
REQ-005 SHALL have port byte_data  input  8  decoded 8b10b byte.
REQ-006 SHALL have port byte_k  input  1  byte is a K (control) code.
REQ-007 SHALL have port byte_err  input  1  code/disparity error on this byte; qualified by byte_valid.
REQ-008 SHALL have port fifo_full  input  1  downstream FIFO cannot accept a write.
REQ-009 SHALL have port fifo_write  output  1  one-cycle write strobe.
REQ-010 SHALL have port fifo_data  output  27  {err, eof, sof, word[23:0]}.
REQ-011 SHALL have port in_frame  output  1  high while state is FRAME.
REQ-012 SHALL have port frame_count  output  FRAME_CNT_W  count of error-free frames, wraps.
REQ-013 SHALL have port err_count  output  8  protocol error count, saturating at 255.
REQ-014 SHALL have port overflow  output  1  sticky; set when a word is dropped on fifo_full.

Function
REQ-015 SHALL recognise control codes: K.28.1 (8'h3C) NOP, K.28.7 (8'hFC) HEADER, K.28.5 (8'hBC) TRAILER; any other K byte is illegal.
REQ-016 SHALL implement states IDLE, FRAME, DROP; cycles with byte_valid=0 change no state and no counters.
REQ-017 IDLE: HEADER -> FRAME with byte_cnt=0, hold empty, first-word flag set; NOP ignored; data byte, TRAILER, illegal K or byte_err -> err_count+1, stay IDLE.
REQ-018 FRAME: data bytes assemble MSB-first: 1st byte -> word[23:16], 2nd -> [15:8], 3rd -> [7:0]; byte_cnt wraps 2->0.
REQ-019 Completed word SHALL enter a one-word hold register (carrying sof = first-word flag); first-word flag then clears.
REQ-020 Data byte arriving with hold full SHALL write hold to FIFO with eof=0, err=0.
REQ-021 TRAILER with byte_cnt=0: write hold with eof=1, err=0 (if hold full), frame_count+1, -> IDLE.
REQ-022 TRAILER with byte_cnt!=0 (partial word): partial bytes discarded, write hold with eof=1, err=1 (if hold full), err_count+1, frame_count unchanged, -> IDLE.
REQ-023 TRAILER with empty frame (no bytes): no write, frame_count unchanged, -> IDLE.
REQ-024 HEADER, illegal K or byte_err in FRAME: write hold with eof=1, err=1 (if hold full), err_count+1; HEADER -> FRAME restarted per REQ-017, others -> IDLE.
REQ-025 NOP inside FRAME SHALL be ignored (idle fill), no error.
REQ-026 fifo_write/fifo_data SHALL be registered: asserted exactly on the cycle after the triggering byte, for one cycle; fifo_data holds its last value when fifo_write=0.
REQ-027 fifo_full is sampled on the triggering byte's cycle; if high, the write is suppressed, overflow set, err_count+1, state -> DROP.
REQ-028 DROP: all bytes discarded without writes; TRAILER -> IDLE; HEADER -> FRAME per REQ-017; no further err_count increments.
REQ-029 err_count SHALL saturate at 8'hFF; frame_count SHALL wrap to 0 after all-ones.
REQ-030 At most one FIFO write per cycle; throughput one byte per cycle sustained.

Reset
REQ-031 reset_n low SHALL asynchronously force state IDLE, byte_cnt 0, hold empty, fifo_write 0, fifo_data 0, in_frame 0, frame_count 0, err_count 0, overflow 0.
REQ-032 Reset mid-frame SHALL discard hold and partial word with no write after release.
REQ-033 overflow SHALL clear only on reset.

Verification
REQ-034 NOP, FC, 11,22,33, 44,55,66, BC -> writes {0,0,1,112233} then {0,1,0,445566}; frame_count=1, err_count=0.
REQ-035 FC, AA,BB,CC, DD, BC -> single write {1,1,1,AABBCC}; err_count=1, frame_count=0.
REQ-036 FC, 01,02,03, FC, 04,05,06, BC -> {1,1,1,010203}, then {0,1,1,040506}; err_count=1, frame_count=1.
REQ-037 fifo_full=1 on the 4th data byte of a 9-byte frame -> 1st word lost, no further writes until BC, overflow=1, err_count=1, next frame decodes normally.
REQ-038 Assert reset_n low after FC, 11,22,33, 44 -> no fifo_write ever; all outputs 0; next frame counts frame_count=1.
REQ-039 300 stray data bytes in IDLE -> err_count=255 (saturated), no writes.

Source files
------------

// File: rtl/rx_frame_decoder.sv
// 8b10b byte-stream frame decoder: packs data bytes into 24-bit words between
// HEADER/TRAILER control codes and pushes tagged words into a downstream FIFO.
module rx_frame_decoder #(
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  input  logic                   byte_k,
  input  logic                   byte_err,
  input  logic                   fifo_full,
  output logic                   fifo_write,
  output logic [26:0]            fifo_data,
  output logic                   in_frame,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic [7:0]             err_count,
  output logic                   overflow
);

  typedef enum logic [1:0] {IDLE, FRAME, DROP} state_e;

  localparam logic [7:0] K_NOP = 8'h3C;
  localparam logic [7:0] K_HDR = 8'hFC;
  localparam logic [7:0] K_TRL = 8'hBC;

  state_e                 state_q, state_d;
  logic [1:0]             byteCnt_q, byteCnt_d;
  logic [15:0]            partial_q, partial_d;
  logic [23:0]            hold_q, hold_d;
  logic                   holdVld_q, holdVld_d;
  logic                   holdSof_q, holdSof_d;
  logic                   first_q, first_d;
  logic                   fifoWrite_q, fifoWrite_d;
  logic [26:0]            fifoData_q, fifoData_d;
  logic [FRAME_CNT_W-1:0] frameCnt_q, frameCnt_d;
  logic [7:0]             errCnt_q, errCnt_d;
  logic                   ovf_q, ovf_d;

  logic isNop, isHdr, isTrl, isIllegal;
  logic wrReq, wrErr, wrEof, errInc, frameInc, restart;

  assign isNop     = byte_k && (byte_data == K_NOP);
  assign isHdr     = byte_k && (byte_data == K_HDR);
  assign isTrl     = byte_k && (byte_data == K_TRL);
  assign isIllegal = byte_k && !isNop && !isHdr && !isTrl;

  always_comb begin
    state_d     = state_q;
    byteCnt_d   = byteCnt_q;
    partial_d   = partial_q;
    hold_d      = hold_q;
    holdVld_d   = holdVld_q;
    holdSof_d   = holdSof_q;
    first_d     = first_q;
    fifoWrite_d = 1'b0;
    fifoData_d  = fifoData_q;
    frameCnt_d  = frameCnt_q;
    errCnt_d    = errCnt_q;
    ovf_d       = ovf_q;
    wrReq       = 1'b0;
    wrErr       = 1'b0;
    wrEof       = 1'b0;
    errInc      = 1'b0;
    frameInc    = 1'b0;
    restart     = 1'b0;

    if (byte_valid) begin
      unique case (state_q)
        IDLE: begin
          if (byte_err)    errInc  = 1'b1;
          else if (isHdr)  restart = 1'b1;
          else if (!isNop) errInc  = 1'b1;
        end
        FRAME: begin
          if (byte_err || isIllegal || isHdr) begin
            wrReq  = holdVld_q;
            wrErr  = 1'b1;
            wrEof  = 1'b1;
            errInc = 1'b1;
            if (isHdr && !byte_err) restart = 1'b1;
            else                    state_d = IDLE;
          end else if (isTrl) begin
            state_d = IDLE;
            wrReq   = holdVld_q;
            wrEof   = 1'b1;
            if (byteCnt_q != 2'd0) begin
              wrErr  = 1'b1;
              errInc = 1'b1;
            end else if (holdVld_q) begin
              frameInc = 1'b1;
            end
          end else if (!byte_k) begin
            // The held word is flushed only when the next word completes, so a
            // frame ending in a partial word can still tag its last full word.
            unique case (byteCnt_q)
              2'd0: begin
                partial_d[15:8] = byte_data;
                byteCnt_d       = 2'd1;
              end
              2'd1: begin
                partial_d[7:0] = byte_data;
                byteCnt_d      = 2'd2;
              end
              default: begin
                wrReq     = holdVld_q;
                hold_d    = {partial_q, byte_data};
                holdVld_d = 1'b1;
                holdSof_d = first_q;
                first_d   = 1'b0;
                byteCnt_d = 2'd0;
              end
            endcase
          end
        end
        DROP: begin
          if (!byte_err && isHdr)      restart = 1'b1;
          else if (!byte_err && isTrl) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    if (restart) begin
      state_d   = FRAME;
      byteCnt_d = 2'd0;
      holdVld_d = 1'b0;
      first_d   = 1'b1;
    end

    if (wrReq) begin
      if (fifo_full) begin
        ovf_d    = 1'b1;
        errInc   = 1'b1;
        frameInc = 1'b0;
        state_d  = DROP;
      end else begin
        fifoWrite_d = 1'b1;
        fifoData_d  = {wrErr, wrEof, holdSof_q, hold_q};
      end
    end

    if (frameInc) frameCnt_d = frameCnt_q + FRAME_CNT_W'(1);
    if (errInc && (errCnt_q != 8'hFF)) errCnt_d = errCnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      byteCnt_q   <= 2'd0;
      partial_q   <= 16'd0;
      hold_q      <= 24'd0;
      holdVld_q   <= 1'b0;
      holdSof_q   <= 1'b0;
      first_q     <= 1'b0;
      fifoWrite_q <= 1'b0;
      fifoData_q  <= 27'd0;
      frameCnt_q  <= '0;
      errCnt_q    <= 8'd0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      byteCnt_q   <= byteCnt_d;
      partial_q   <= partial_d;
      hold_q      <= hold_d;
      holdVld_q   <= holdVld_d;
      holdSof_q   <= holdSof_d;
      first_q     <= first_d;
      fifoWrite_q <= fifoWrite_d;
      fifoData_q  <= fifoData_d;
      frameCnt_q  <= frameCnt_d;
      errCnt_q    <= errCnt_d;
      ovf_q       <= ovf_d;
    end
  end

  assign fifo_write  = fifoWrite_q;
  assign fifo_data   = fifoData_q;
  assign in_frame    = (state_q == FRAME);
  assign frame_count = frameCnt_q;
  assign err_count   = errCnt_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_rx_frame_decoder.sv
// Directed bench for rx_frame_decoder; a narrow frame counter makes the wrap
// boundary reachable in a few frames.
module tb_rx_frame_decoder;

  localparam int FCW = 3;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           byte_valid;
  logic [7:0]     byte_data;
  logic           byte_k;
  logic           byte_err;
  logic           fifo_full;
  logic           fifo_write;
  logic [26:0]    fifo_data;
  logic           in_frame;
  logic [FCW-1:0] frame_count;
  logic [7:0]     err_count;
  logic           overflow;

  int checks = 0;
  int failures = 0;
  logic [26:0] wrQ[$];

  rx_frame_decoder #(.FRAME_CNT_W(FCW)) dut (
    .clk(clk), .reset_n(reset_n), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_k(byte_k), .byte_err(byte_err), .fifo_full(fifo_full),
    .fifo_write(fifo_write), .fifo_data(fifo_data), .in_frame(in_frame),
    .frame_count(frame_count), .err_count(err_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Drives one cycle of input, then samples #1 after the edge and logs any write.
  task automatic applyStimulus(input logic v, input logic k, input logic [7:0] d,
                               input logic full, input logic berr);
    byte_valid = v;
    byte_k     = k;
    byte_data  = d;
    fifo_full  = full;
    byte_err   = berr;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    fifo_full  = 1'b0;
    byte_err   = 1'b0;
    if (fifo_write === 1'b1) wrQ.push_back(fifo_data);
  endtask

  task automatic sendData(input logic [7:0] d);
    applyStimulus(1'b1, 1'b0, d, 1'b0, 1'b0);
  endtask

  task automatic sendK(input logic [7:0] d);
    applyStimulus(1'b1, 1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic resetDut();
    reset_n    = 1'b0;
    byte_valid = 1'b0;
    byte_k     = 1'b0;
    byte_data  = 8'h00;
    byte_err   = 1'b0;
    fifo_full  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    wrQ.delete();
  endtask

  task automatic test_reset();
    resetDut();
    checks += 6;
    if (fifo_write !== 1'b0) begin failures++; $display("[TB] FAIL reset_fifo_write got=%0b exp=0", fifo_write); end
    if (fifo_data !== 27'd0) begin failures++; $display("[TB] FAIL reset_fifo_data got=%h exp=0", fifo_data); end
    if (in_frame !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_frame got=%0b exp=0", in_frame); end
    if (frame_count !== 3'd0) begin failures++; $display("[TB] FAIL reset_frame_count got=%0d exp=0", frame_count); end
    if (err_count !== 8'd0) begin failures++; $display("[TB] FAIL reset_err_count got=%0d exp=0", err_count); end
    if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_overflow got=%0b exp=0", overflow); end
  endtask

  task automatic test_basic();
    resetDut();
    sendK(8'h3C);
    sendK(8'hFC);
    checks++;
    if (in_frame !== 1'b1) begin failures++; $display("[TB] FAIL basic_in_frame got=%0b exp=1", in_frame); end
    sendData(8'h11); sendData(8'h22); sendData(8'h33);
    sendData(8'h44); sendData(8'h55);
    checks++;
    if (fifo_write !== 1'b0) begin failures++; $display("[TB] FAIL basic_no_early_write got=%0b exp=0", fifo_write); end
    sendData(8'h66);
    checks++;
    if (fifo_write !== 1'b1 || fifo_data !== 27'h1112233) begin
      failures++; $display("[TB] FAIL basic_word1_timing got=%0b/%h exp=1/1112233", fifo_write, fifo_data);
    end
    sendK(8'hBC);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checks += 6;
    if (wrQ.size() != 2) begin failures++; $display("[TB] FAIL basic_write_count got=%0d exp=2", wrQ.size()); end
    else begin
      if (wrQ[0] !== 27'h1112233) begin failures++; $display("[TB] FAIL basic_w0 got=%h exp=1112233", wrQ[0]); end
      if (wrQ[1] !== 27'h2445566) begin failures++; $display("[TB] FAIL basic_w1 got=%h exp=2445566", wrQ[1]); end
    end
    if (fifo_write !== 1'b0 || fifo_data !== 27'h2445566) begin
      failures++; $display("[TB] FAIL basic_data_hold got=%0b/%h exp=0/2445566", fifo_write, fifo_data);
    end
    if (frame_count !== 3'd1) begin failures++; $display("[TB] FAIL basic_frame_count got=%0d exp=1", frame_count); end
    if (err_count !== 8'd0) begin failures++; $display("[TB] FAIL basic_err_count got=%0d exp=0", err_count); end
    if (in_frame !== 1'b0) begin failures++; $display("[TB] FAIL basic_in_frame_after got=%0b exp=0", in_frame); end
  endtask

  task automatic test_partial();
    resetDut();
    sendK(8'hFC);
    sendData(8'hAA); sendData(8'hBB); sendData(8'hCC); sendData(8'hDD);
    sendK(8'hBC);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checks += 3;
    if (wrQ.size() != 1 || wrQ[0] !== 27'h7AABBCC) begin
      failures++; $display("[TB] FAIL partial_write got=%0d/%h exp=1/7aabbcc", wrQ.size(), (wrQ.size() > 0) ? wrQ[0] : 27'd0);
    end
    if (err_count !== 8'd1) begin failures++; $display("[TB] FAIL partial_err_count got=%0d exp=1", err_count); end
    if (frame_count !== 3'd0) begin failures++; $display("[TB] FAIL partial_frame_count got=%0d exp=0", frame_count); end
  endtask

  task automatic test_back_to_back();
    resetDut();
    sendK(8'hFC);
    sendData(8'h01); sendData(8'h02); sendData(8'h03);
    sendK(8'hFC);
    checks++;
    if (fifo_write !== 1'b1 || fifo_data !== 27'h7010203) begin
      failures++; $display("[TB] FAIL b2b_header_write got=%0b/%h exp=1/7010203", fifo_write, fifo_data);
    end
    sendData(8'h04);
    checks++;
    if (fifo_write !== 1'b0) begin failures++; $display("[TB] FAIL b2b_one_cycle got=%0b exp=0", fifo_write); end
    sendData(8'h05); sendData(8'h06);
    sendK(8'hBC);
    checks += 4;
    if (wrQ.size() != 2) begin failures++; $display("[TB] FAIL b2b_write_count got=%0d exp=2", wrQ.size()); end
    else if (wrQ[1] !== 27'h3040506) begin failures++; $display("[TB] FAIL b2b_w1 got=%h exp=3040506", wrQ[1]); end
    if (err_count !== 8'd1) begin failures++; $display("[TB] FAIL b2b_err_count got=%0d exp=1", err_count); end
    if (frame_count !== 3'd1) begin failures++; $display("[TB] FAIL b2b_frame_count got=%0d exp=1", frame_count); end
    if (in_frame !== 1'b0) begin failures++; $display("[TB] FAIL b2b_in_frame got=%0b exp=0", in_frame); end
  endtask

  // fifo_full is held from the 4th data byte on so the word-completing 6th byte sees it.
  task automatic test_overflow();
    resetDut();
    sendK(8'hFC);
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(1'b1, 1'b0, 8'(i), (i >= 4), 1'b0);
      if (i == 7) begin
        checks++;
        if (in_frame !== 1'b0) begin failures++; $display("[TB] FAIL ovf_left_frame got=%0b exp=0", in_frame); end
      end
    end
    sendK(8'hBC);
    checks += 4;
    if (wrQ.size() != 0) begin failures++; $display("[TB] FAIL ovf_no_writes got=%0d exp=0", wrQ.size()); end
    if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_flag got=%0b exp=1", overflow); end
    if (err_count !== 8'd1) begin failures++; $display("[TB] FAIL ovf_err_count got=%0d exp=1", err_count); end
    if (frame_count !== 3'd0) begin failures++; $display("[TB] FAIL ovf_frame_count got=%0d exp=0", frame_count); end
    sendK(8'hFC);
    sendData(8'hA1); sendData(8'hA2); sendData(8'hA3);
    sendK(8'hBC);
    checks += 4;
    if (wrQ.size() != 1 || wrQ[0] !== 27'h3A1A2A3) begin
      failures++; $display("[TB] FAIL ovf_next_frame got=%0d/%h exp=1/3a1a2a3", wrQ.size(), (wrQ.size() > 0) ? wrQ[0] : 27'd0);
    end
    if (frame_count !== 3'd1) begin failures++; $display("[TB] FAIL ovf_next_count got=%0d exp=1", frame_count); end
    if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_sticky got=%0b exp=1", overflow); end
    if (err_count !== 8'd1) begin failures++; $display("[TB] FAIL ovf_err_stable got=%0d exp=1", err_count); end
  endtask

  task automatic test_reset_midframe();
    resetDut();
    sendK(8'hFC);
    sendData(8'h11); sendData(8'h22); sendData(8'h33); sendData(8'h44);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({fifo_write, fifo_data, in_frame, frame_count, err_count, overflow} !== '0) begin
      failures++; $display("[TB] FAIL midreset_async got=%0b/%h/%0b/%0d/%0d/%0b exp=all0",
                           fifo_write, fifo_data, in_frame, frame_count, err_count, overflow);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checks += 2;
    if (wrQ.size() != 0) begin failures++; $display("[TB] FAIL midreset_no_write got=%0d exp=0", wrQ.size()); end
    if (in_frame !== 1'b0) begin failures++; $display("[TB] FAIL midreset_in_frame got=%0b exp=0", in_frame); end
    sendK(8'hFC);
    sendData(8'h01); sendData(8'h02); sendData(8'h03);
    sendK(8'hBC);
    checks += 2;
    if (frame_count !== 3'd1) begin failures++; $display("[TB] FAIL midreset_frame_count got=%0d exp=1", frame_count); end
    if (wrQ.size() != 1 || wrQ[0] !== 27'h3010203) begin
      failures++; $display("[TB] FAIL midreset_write got=%0d/%h exp=1/3010203", wrQ.size(), (wrQ.size() > 0) ? wrQ[0] : 27'd0);
    end
  endtask

  task automatic test_errors();
    resetDut();
    applyStimulus(1'b0, 1'b1, 8'hFC, 1'b0, 1'b1);
    checks += 2;
    if (in_frame !== 1'b0) begin failures++; $display("[TB] FAIL err_invalid_ignored got=%0b exp=0", in_frame); end
    if (err_count !== 8'd0) begin failures++; $display("[TB] FAIL err_invalid_count got=%0d exp=0", err_count); end
    sendK(8'hFC);
    sendK(8'hBC);
    checks += 3;
    if (wrQ.size() != 0) begin failures++; $display("[TB] FAIL err_empty_frame got=%0d exp=0", wrQ.size()); end
    if (frame_count !== 3'd0) begin failures++; $display("[TB] FAIL err_empty_count got=%0d exp=0", frame_count); end
    if (err_count !== 8'd0) begin failures++; $display("[TB] FAIL err_empty_err got=%0d exp=0", err_count); end
    sendK(8'hFC);
    sendData(8'h11); sendK(8'h3C); sendData(8'h22);
    applyStimulus(1'b0, 1'b0, 8'hEE, 1'b0, 1'b0);
    sendData(8'h33);
    sendK(8'hF7);
    checks += 3;
    if (wrQ.size() != 1 || wrQ[0] !== 27'h7112233) begin
      failures++; $display("[TB] FAIL err_illegal_k got=%0d/%h exp=1/7112233", wrQ.size(), (wrQ.size() > 0) ? wrQ[0] : 27'd0);
    end
    if (err_count !== 8'd1) begin failures++; $display("[TB] FAIL err_illegal_count got=%0d exp=1", err_count); end
    if (in_frame !== 1'b0) begin failures++; $display("[TB] FAIL err_illegal_idle got=%0b exp=0", in_frame); end
    sendK(8'hFC);
    sendData(8'h44); sendData(8'h55); sendData(8'h66);
    applyStimulus(1'b1, 1'b0, 8'h77, 1'b0, 1'b1);
    checks += 2;
    if (wrQ.size() != 2 || wrQ[1] !== 27'h7445566) begin
      failures++; $display("[TB] FAIL err_byte_err got=%0d/%h exp=2/7445566", wrQ.size(), (wrQ.size() > 1) ? wrQ[1] : 27'd0);
    end
    if (err_count !== 8'd2) begin failures++; $display("[TB] FAIL err_byte_err_count got=%0d exp=2", err_count); end
  endtask

  task automatic test_frame_wrap();
    resetDut();
    for (int f = 0; f < 8; f++) begin
      sendK(8'hFC);
      sendData(8'h01); sendData(8'h02); sendData(8'h03);
      sendK(8'hBC);
      if (f == 6) begin
        checks++;
        if (frame_count !== 3'd7) begin failures++; $display("[TB] FAIL wrap_at_max got=%0d exp=7", frame_count); end
      end
    end
    checks += 2;
    if (frame_count !== 3'd0) begin failures++; $display("[TB] FAIL wrap_to_zero got=%0d exp=0", frame_count); end
    if (wrQ.size() != 8) begin failures++; $display("[TB] FAIL wrap_write_count got=%0d exp=8", wrQ.size()); end
  endtask

  task automatic test_saturation();
    resetDut();
    for (int i = 0; i < 300; i++) begin
      sendData(8'h55);
      if (i == 253) begin
        checks++;
        if (err_count !== 8'd254) begin failures++; $display("[TB] FAIL sat_before got=%0d exp=254", err_count); end
      end
    end
    checks += 2;
    if (err_count !== 8'd255) begin failures++; $display("[TB] FAIL sat_err_count got=%0d exp=255", err_count); end
    if (wrQ.size() != 0) begin failures++; $display("[TB] FAIL sat_no_writes got=%0d exp=0", wrQ.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_back_to_back();
    test_overflow();
    test_reset_midframe();
    test_errors();
    test_frame_wrap();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
